alu_req_scheduler: RTL and testbench
====================================

// Module: alu_req_scheduler
// PURPOSE
//  Shares one registered ALU subsystem (input reg -> ALU -> output reg, LAT cycles) between
//  two requesters. Round-robin arbitration, valid/ready request handshake, one op in flight,
//  registered response with result, flags and requester id. Sits between client masters
//  and the ALU subsystem's a/b/s inputs and result/flag outputs.
// PARAMETERS
//  N        32  operand/result width
//  LAT      2   cycles from ALU input-reg capture edge to output-reg capture edge, inclusive (>=1)
//  NUM_OPS  10  legal opcodes are 0..NUM_OPS-1 (used only with ALU_SCHED_OPCHECK_EN)
// PORTS
//  clk         in   1     clock, rising edge
//  rst         in   1     asynchronous, active-low reset
//  req_valid   in   2     per-requester request valid
//  req_ready   out  2     per-requester accept, one-hot or zero
//  req_a       in   2*N   operand A; requester i at [i*N +: N]
//  req_b       in   2*N   operand B, same packing
//  req_op      in   8     opcode; requester i at [i*4 +: 4]
//  alu_a       out  N     to ALU subsystem operand A
//  alu_b       out  N     to ALU subsystem operand B
//  alu_s       out  4     to ALU subsystem opcode
//  alu_result  in   N     from ALU subsystem output register
//  alu_flags   in   4     from ALU subsystem: [0]neg [1]zero [2]carry [3]overflow
//  rsp_valid   out  1     response valid
//  rsp_ready   in   1     response accept
//  rsp_id      out  1     requester that owns the response
//  rsp_result  out  N     registered result
//  rsp_flags   out  4     registered flags, same bit order as alu_flags
//  rsp_err     out  1     illegal-opcode response (constant 0 without macro)
//  busy        out  1     high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, cnt=0, last=1 (requester 0 wins first tie); all outputs 0.
//  States IDLE, WAIT, RESP. Only one op in flight; req_ready is 0 outside IDLE.
//  IDLE: if any req_valid, grant g: sole requester, or on both valid the one != last.
//   req_ready[g]=1 combinationally that cycle (only that bit). At the edge: alu_a/b/s <= req
//   operands of g, id <= g, last <= g, cnt <= LAT, -> WAIT. No valid: stay, req_ready=0.
//  WAIT: alu_a/b/s held stable. cnt decrements each cycle; when cnt==0, at the edge
//   rsp_result<=alu_result, rsp_flags<=alu_flags, rsp_id<=id, rsp_valid<=1, -> RESP.
//   Accept edge E0 -> rsp_valid high after edge E(LAT+1) (LAT=2: 3 cycles after accept).
//  RESP: rsp_* held stable while rsp_valid && !rsp_ready. rsp_valid&&rsp_ready at edge:
//   rsp_valid<=0, -> IDLE. Next acceptance earliest the cycle after; min op period LAT+3.
//  req_valid dropping during WAIT/RESP has no effect; operands were captured at acceptance.
//  rsp_ready high outside RESP is ignored.
//  Reset mid-operation: in-flight op dropped, no response; ALU subsystem shares rst.
//  Widths: no arithmetic on data; cnt width $clog2(LAT+1); result/flags passed unmodified.
// CONFIGURATION
//  ALU_SCHED_OPCHECK_EN defined: in IDLE a granted request with op >= NUM_OPS is accepted
//   normally (req_ready, last updated) but not issued: alu_a/b/s unchanged, -> RESP directly
//   with rsp_err=1, rsp_result=0, rsp_flags=0, rsp_valid high after the accept edge.
//   Legal ops give rsp_err=0.
//  Not defined: no opcode check, every op issued, rsp_err tied 0.
// TESTING
//  1 Reset: rst=0 mid-WAIT -> all outputs 0, state IDLE, no rsp_valid after rst=1.
//  2 Single: req0 a=5,b=3,op=0 (ADD), rsp_ready=1 -> req_ready=2'b01, rsp_valid 3 cycles
//    later with result=8, flags=4'b0000, id=0; busy high from accept through RESP.
//  3 Arbitration: both valid continuously, rsp_ready=1 -> grants 0,1,0,1; rsp_id same order.
//  4 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=2'b00;
//    rsp_ready=1 -> IDLE next cycle, pending requester accepted.
//  5 Flags: req1 a=32'h7FFFFFFF,b=1,op=0 -> result=32'h80000000, flags=4'b1001, id=1.
//  6 OPCHECK_EN: req0 op=4'hF -> rsp_err=1, result=0, flags=0 one cycle after accept,
//    alu_s unchanged; without macro the op is issued and rsp_err=0.

Source files
------------

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler that shares one registered ALU subsystem between two requesters.
// Optional opcode check: define ALU_SCHED_OPCHECK_EN to answer illegal opcodes with rsp_err.
module alu_req_scheduler #(
  parameter int N       = 32,
  parameter int LAT     = 2,
  parameter int NUM_OPS = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*N-1:0] req_a,
  input  logic [2*N-1:0] req_b,
  input  logic [7:0]     req_op,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [3:0]     alu_s,
  input  logic [N-1:0]   alu_result,
  input  logic [3:0]     alu_flags,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [N-1:0]   rsp_result,
  output logic [3:0]     rsp_flags,
  output logic           rsp_err,
  output logic           busy,
  output logic [1:0]     dbg_state
);

  localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

`ifdef ALU_SCHED_OPCHECK_EN
  localparam bit OPCHECK_ON = 1'b1;
`else
  localparam bit OPCHECK_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Handshake: a request transfers on an edge where req_valid[i] && req_ready[i];
  // a response transfers on an edge where rsp_valid && rsp_ready. Neither valid
  // depends on its ready, and req_ready is only ever raised in IDLE.

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               id_q, id_d;
  logic [N-1:0]       alu_a_q, alu_a_d;
  logic [N-1:0]       alu_b_q, alu_b_d;
  logic [3:0]         alu_s_q, alu_s_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [N-1:0]       rsp_result_q, rsp_result_d;
  logic [3:0]         rsp_flags_q, rsp_flags_d;
  logic               rsp_err_q, rsp_err_d;

  logic               gnt_id;
  logic [N-1:0]       gnt_a;
  logic [N-1:0]       gnt_b;
  logic [3:0]         gnt_op;
  logic               op_illegal;

  // On a tie the requester that did not win last time gets the grant.
  assign gnt_id     = (&req_valid) ? ~last_q : req_valid[1];
  assign gnt_a      = gnt_id ? req_a[2*N-1:N] : req_a[N-1:0];
  assign gnt_b      = gnt_id ? req_b[2*N-1:N] : req_b[N-1:0];
  assign gnt_op     = gnt_id ? req_op[7:4] : req_op[3:0];
  assign op_illegal = OPCHECK_ON && (int'({28'b0, gnt_op}) >= NUM_OPS);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    id_d         = id_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_s_d      = alu_s_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    req_ready    = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready[gnt_id] = 1'b1;
          last_d            = gnt_id;
          id_d              = gnt_id;
          if (op_illegal) begin
            // Answered locally; the ALU inputs keep their previous values.
            rsp_valid_d  = 1'b1;
            rsp_id_d     = gnt_id;
            rsp_result_d = '0;
            rsp_flags_d  = '0;
            rsp_err_d    = 1'b1;
            state_d      = S_RESP;
          end else begin
            alu_a_d = gnt_a;
            alu_b_d = gnt_b;
            alu_s_d = gnt_op;
            cnt_d   = CNT_W'(LAT);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rsp_valid_d  = 1'b1;
          rsp_id_d     = id_q;
          rsp_result_d = alu_result;
          rsp_flags_d  = alu_flags;
          rsp_err_d    = 1'b0;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b1;
      id_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_s_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      id_q         <= id_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_s_q      <= alu_s_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_s      = alu_s_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler with a two-stage registered ALU model (LAT=2).
module tb_alu_req_scheduler;

  localparam int N = 32;

  logic           clk;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*N-1:0] req_a;
  logic [2*N-1:0] req_b;
  logic [7:0]     req_op;
  logic [N-1:0]   alu_a;
  logic [N-1:0]   alu_b;
  logic [3:0]     alu_s;
  logic [N-1:0]   alu_result;
  logic [3:0]     alu_flags;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [N-1:0]   rsp_result;
  logic [3:0]     rsp_flags;
  logic           rsp_err;
  logic           busy;
  logic [1:0]     dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] exp_q[$];
  logic [1:0]   gnt_q[$];

  alu_req_scheduler #(.N(N), .LAT(2), .NUM_OPS(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU subsystem model: input register, then output register (2 capture edges).
  logic [N-1:0] in_a, in_b;
  logic [3:0]   in_s;

  function automatic logic [N+3:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [3:0] s);
    logic [N:0]   sum;
    logic [N-1:0] r;
    logic         c, v;
    c = 1'b0;
    v = 1'b0;
    case (s)
      4'd0: begin
        sum = {1'b0, a} + {1'b0, b};
        r = sum[N-1:0];
        c = sum[N];
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      default: r = a;
    endcase
    return {v, c, (r == '0), r[N-1], r};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_a <= '0; in_b <= '0; in_s <= '0;
      alu_result <= '0; alu_flags <= '0;
    end else begin
      in_a <= alu_a; in_b <= alu_b; in_s <= alu_s;
      {alu_flags, alu_result} <= alu_f(in_a, in_b, in_s);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // driver tasks
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Presents a request, waits for its grant, returns just after the accept edge.
  task automatic issue(input int who, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [3:0] op);
    int k;
    req_a[who*N +: N] = a;
    req_b[who*N +: N] = b;
    req_op[who*4 +: 4] = op;
    req_valid[who] = 1'b1;
    k = 0;
    @(negedge clk);
    while (!req_ready[who] && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_ready", 64'(req_ready), 64'(2'b01 << who));
    @(posedge clk);
    #1 req_valid[who] = 1'b0;
  endtask

  // Counts negedges after the accept edge until rsp_valid; checks busy meanwhile.
  task automatic wait_rsp(output int lat);
    lat = 0;
    @(negedge clk);
    check("busy", 64'(busy), 64'd1);
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      check("busy", 64'(busy), 64'd1);
    end
    if (lat >= 20) check("rsp_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int lat;
    int seen;
    int nrsp;
    int cyc;
    int last_gnt_cyc;
    logic [3:0]   prev_s;
    logic [N-1:0] prev_a;
    logic [1:0]   g;

    rst = 1'b0;
    req_valid = 2'b00;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b1;

    // Reset state
    #12;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single ADD from requester 0
    issue(0, 32'd5, 32'd3, 4'd0);
    wait_rsp(lat);
    check("single_lat", 64'(lat), 64'd3);
    check("single_result", 64'(rsp_result), 64'd8);
    check("single_flags", 64'(rsp_flags), 64'h0);
    check("single_id", 64'(rsp_id), 64'd0);
    check("single_err", 64'(rsp_err), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("single_idle_busy", 64'(busy), 64'd0);
    check("single_idle_valid", 64'(rsp_valid), 64'd0);

    // Reset in the middle of WAIT
    issue(0, 32'd1, 32'd2, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'd0);
    check("midrst_alu_a", 64'(alu_a), 64'd0);
    check("midrst_alu_b", 64'(alu_b), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("midrst_no_rsp", 64'(seen), 64'd0);

    // Arbitration: both valid continuously from reset -> 0,1,0,1
    pulse_reset();
    gnt_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    req_a = {32'd20, 32'd10};
    req_b = {32'd2, 32'd1};
    req_op = {4'd1, 4'd0};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    nrsp = 0;
    cyc = 0;
    last_gnt_cyc = -1;
    while (nrsp < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (req_ready != 2'b00) begin
        g = (gnt_q.size() != 0) ? gnt_q.pop_front() : 2'b00;
        check("arb_grant", 64'(req_ready), 64'(g));
        if (last_gnt_cyc >= 0) check("arb_period", 64'(cyc - last_gnt_cyc), 64'd5);
        last_gnt_cyc = cyc;
        exp_q.push_back(req_ready[1] ? 32'd18 : 32'd11);
      end
      if (rsp_valid) begin
        nrsp++;
        if (exp_q.size() != 0) begin
          prev_a = exp_q.pop_front();
          check("arb_result", 64'(rsp_result), 64'(prev_a));
          check("arb_id", 64'(rsp_id), 64'(prev_a == 32'd18));
        end else begin
          check("arb_unexpected_rsp", 64'd1, 64'd0);
        end
      end
    end
    check("arb_rsp_count", 64'(nrsp), 64'd4);
    @(posedge clk);
    #1 req_valid = 2'b00;

    // Backpressure with requester 1 pending
    rsp_ready = 1'b0;
    issue(0, 32'd100, 32'd23, 4'd0);
    req_a[N +: N] = 32'd1;
    req_b[N +: N] = 32'd1;
    req_op[7:4] = 4'd2;
    req_valid[1] = 1'b1;
    wait_rsp(lat);
    check("bp_result", 64'(rsp_result), 64'd123);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_result_hold", 64'(rsp_result), 64'd123);
      check("bp_id_hold", 64'(rsp_id), 64'd0);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_state", 64'(dbg_state), 64'd0);
    check("bp_pending_grant", 64'(req_ready), 64'(2'b10));
    check("bp_valid_drop", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_rsp(lat);
    check("bp2_lat", 64'(lat), 64'd3);
    check("bp2_result", 64'(rsp_result), 64'd1);
    check("bp2_id", 64'(rsp_id), 64'd1);
    @(posedge clk);
    #1;

    // Overflow flags from requester 1
    issue(1, 32'h7FFF_FFFF, 32'd1, 4'd0);
    wait_rsp(lat);
    check("flags_result", 64'(rsp_result), 64'h8000_0000);
    check("flags_flags", 64'(rsp_flags), 64'(4'b1001));
    check("flags_id", 64'(rsp_id), 64'd1);
    check("flags_err", 64'(rsp_err), 64'd0);
    @(posedge clk);
    #1;

    // Opcode 0xF
    prev_s = alu_s;
    prev_a = alu_a;
    issue(0, 32'd9, 32'd4, 4'hF);
    wait_rsp(lat);
`ifdef ALU_SCHED_OPCHECK_EN
    check("opchk_lat", 64'(lat), 64'd0);
    check("opchk_err", 64'(rsp_err), 64'd1);
    check("opchk_result", 64'(rsp_result), 64'd0);
    check("opchk_flags", 64'(rsp_flags), 64'd0);
    check("opchk_alu_s", 64'(alu_s), 64'(prev_s));
    check("opchk_alu_a", 64'(alu_a), 64'(prev_a));
`else
    check("opF_lat", 64'(lat), 64'd3);
    check("opF_err", 64'(rsp_err), 64'd0);
    check("opF_result", 64'(rsp_result), 64'd9);
    check("opF_alu_s", 64'(alu_s), 64'hF);
`endif
    check("opF_id", 64'(rsp_id), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("final_idle", 64'(dbg_state), 64'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
